// File: rtl/uart_pkg.sv
// Shared definitions for the UART echo controller: FSM encoding, ASCII
// case-conversion constants and the uppercase transform.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_GAP  = 2'd3
    } uart_state_t;

    localparam logic [7:0] ASCII_LC_A     = 8'h61;
    localparam logic [7:0] ASCII_LC_Z     = 8'h7A;
    localparam logic [7:0] ASCII_CASE_OFS = 8'h20;

    function automatic logic [7:0] upcase_byte(input logic [7:0] b);
        return ((b >= ASCII_LC_A) && (b <= ASCII_LC_Z)) ? (b - ASCII_CASE_OFS) : b;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Byte FIFO with registered occupancy flags and a registered read port that
// updates only on pop, so the popped byte stays put until the next pop.
module uart_sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic [7:0]        i_wr_data,
    input  logic              i_pop,
    output logic [7:0]        o_rd_data,
    output logic [ADDR_W:0]   o_count,
    output logic              o_full,
    output logic              o_empty
);
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [7:0]        r_rd_data;
    logic              r_full;
    logic              r_empty;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W:0]   w_count_next;

    // A full FIFO still takes a write when the same cycle frees a slot.
    assign w_pop  = i_pop && !r_empty;
    assign w_push = i_push && (!r_full || w_pop);

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + (ADDR_W + 1)'(1);
            2'b01:   w_count_next = r_count - (ADDR_W + 1)'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rd_data <= '0;
            r_full    <= 1'b0;
            r_empty   <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + ADDR_W'(1);
                r_rd_data <= r_mem[r_rd_ptr];
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == FULL_COUNT);
            r_empty <= (w_count_next == '0);
        end
    end

    assign o_rd_data = r_rd_data;
    assign o_count   = r_count;
    assign o_full    = r_full;
    assign o_empty   = r_empty;

endmodule

// File: rtl/uart_echo_ctrl.sv
// Loopback responder: buffers received bytes and replays them one at a time
// through the transmitter handshake, with optional gap and uppercase mapping.
module uart_echo_ctrl
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 4,
    parameter int GAP_CLKS   = 0,
    parameter int UPCASE_EN  = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rx_dv,
    input  logic [7:0]        i_rx_byte,
    input  logic              i_tx_active,
    input  logic              i_tx_done,
    output logic              o_tx_dv,
    output logic [7:0]        o_tx_byte,
    output logic [ADDR_W:0]   o_fifo_count,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_overflow
);
    localparam int GAP_W = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

    uart_state_t      r_state;
    uart_state_t      w_state_next;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_overflow;
    logic             w_pop;
    logic             w_empty;
    logic             w_full;
    logic [7:0]       w_rd_data;

    uart_sync_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_push    (i_rx_dv),
        .i_wr_data (i_rx_byte),
        .i_pop     (w_pop),
        .o_rd_data (w_rd_data),
        .o_count   (o_fifo_count),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (!w_empty && !i_tx_active) w_state_next = ST_SEND;
            ST_SEND: w_state_next = ST_WAIT;
            ST_WAIT: if (i_tx_done) w_state_next = (GAP_CLKS == 0) ? ST_IDLE : ST_GAP;
            ST_GAP:  if (r_gap_cnt == '0) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_tx_dv = 1'b0;
        w_pop   = 1'b0;
        case (r_state)
            ST_IDLE: w_pop = !w_empty && !i_tx_active;
            ST_SEND: o_tx_dv = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_gap_cnt <= '0;
        end else if ((r_state == ST_WAIT) && i_tx_done && (GAP_CLKS != 0)) begin
            r_gap_cnt <= GAP_W'(GAP_CLKS - 1);
        end else if ((r_state == ST_GAP) && (r_gap_cnt != '0)) begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
        end
    end

    // A dropped byte is one that arrives while full with no pop to make room.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_overflow <= 1'b0;
        end else if (i_rx_dv && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    // The FIFO read register only changes on pop, so the byte holds through WAIT.
    assign o_tx_byte  = (UPCASE_EN != 0) ? upcase_byte(w_rd_data) : w_rd_data;
    assign o_empty    = w_empty;
    assign o_full     = w_full;
    assign o_overflow = r_overflow;

endmodule
